// File: rtl/mac_accumulator_pkg.sv
// mac_accumulator_pkg: widths and state encoding shared by the accumulator and its output slot
package mac_accumulator_pkg;
  localparam int OUT_WIDTH = 16;
  localparam int N_SAMPLES = 8;
  localparam int ACC_WIDTH = OUT_WIDTH + $clog2(N_SAMPLES);
  typedef enum logic {ACCUM, PENDING} state_t;
endpackage

// File: rtl/mac_out_slot.sv
// mac_out_slot: holds the latest block result on a valid/ready port with sticky overrun
import mac_accumulator_pkg::*;
module mac_out_slot #(
  parameter int OUT_WIDTH = mac_accumulator_pkg::OUT_WIDTH,
  parameter int N_SAMPLES = mac_accumulator_pkg::N_SAMPLES,
  parameter int ACC_WIDTH = mac_accumulator_pkg::ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ACC_WIDTH-1:0] data,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] sum_out,
  output logic [OUT_WIDTH-1:0] mean_out,
  output logic                 out_valid,
  output logic                 overrun
);
  localparam int SH = $clog2(N_SAMPLES);
  state_t state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      sum_out   <= '0;
      mean_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (load) begin
      state     <= PENDING;
      sum_out   <= data;
      mean_out  <= OUT_WIDTH'(data >> SH);
      out_valid <= 1'b1;
      if (state == PENDING && !out_ready) overrun <= 1'b1;
    end else if (state == PENDING && out_ready) begin
      state     <= ACCUM;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums N_SAMPLES valid upstream words into a block sum and mean, never stalling
import mac_accumulator_pkg::*;
module mac_accumulator #(
  parameter int OUT_WIDTH = mac_accumulator_pkg::OUT_WIDTH,
  parameter int N_SAMPLES = mac_accumulator_pkg::N_SAMPLES,
  parameter int ACC_WIDTH = OUT_WIDTH + $clog2(N_SAMPLES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [OUT_WIDTH-1:0]         in_data,
  input  logic                         clear,
  output logic [ACC_WIDTH-1:0]         sum_out,
  output logic [OUT_WIDTH-1:0]         mean_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun,
  output logic [$clog2(N_SAMPLES)-1:0] sample_cnt
);
  localparam int CW = $clog2(N_SAMPLES);
  if (ACC_WIDTH < OUT_WIDTH + CW) begin : g_acc_check
    $error("ACC_WIDTH too narrow for N_SAMPLES words of OUT_WIDTH");
  end
  if (N_SAMPLES < 2 || (N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_n_check
    $error("N_SAMPLES must be a power of two >= 2");
  end
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 accept;
  logic                 last;
  logic                 load;
  always_comb begin
    accept   = in_valid && !clear;
    last     = sample_cnt == CW'(N_SAMPLES - 1);
    load     = accept && last;
    acc_next = acc + ACC_WIDTH'(in_data);
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (accept) begin
      acc        <= last ? '0 : acc_next;
      sample_cnt <= last ? '0 : sample_cnt + 1'b1;
    end
  end
  mac_out_slot #(
    .OUT_WIDTH(OUT_WIDTH),
    .N_SAMPLES(N_SAMPLES),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data      (acc_next),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .mean_out  (mean_out),
    .out_valid (out_valid),
    .overrun   (overrun)
  );
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed vectors with a scoreboard checked on every accepted result
module tb_mac_accumulator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [18:0] sum_out;
  logic [15:0] mean_out;
  logic        out_valid;
  logic        overrun;
  logic [2:0]  sample_cnt;
  typedef struct {
    int sum;
    int mean;
    int ovr;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  mac_accumulator dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .clear      (clear),
    .sum_out    (sum_out),
    .mean_out   (mean_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .sample_cnt (sample_cnt)
  );
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input logic v, input int d);
    in_valid = v;
    in_data  = 16'(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic block(input int d, input int n);
    for (int i = 0; i < n; i++) step(1'b1, d);
  endtask
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: result %0d accepted with nothing expected", sum_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_sum", int'(sum_out), e.sum);
        chk("sb_mean", int'(mean_out), e.mean);
        chk("sb_overrun", int'(overrun), e.ovr);
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_sum", int'(sum_out), 0);
    chk("rst_mean", int'(mean_out), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_cnt", int'(sample_cnt), 0);
    block(100, 7);
    chk("t1_cnt7", int'(sample_cnt), 7);
    chk("t1_valid_early", int'(out_valid), 0);
    step(1'b1, 100);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_cnt0", int'(sample_cnt), 0);
    q.push_back('{800, 100, 0});
    out_ready = 1'b1;
    step(1'b0, 0);
    chk("t1_valid_fall", int'(out_valid), 0);
    chk("t1_sum_hold", int'(sum_out), 800);
    q.push_back('{524280, 65535, 0});
    block(65535, 8);
    chk("t2_valid", int'(out_valid), 1);
    step(1'b0, 0);
    chk("t2_pulse", int'(out_valid), 0);
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, i);
      if (i < 8) begin
        step(1'b0, 0);
        step(1'b0, 0);
      end
      if (i == 4) chk("t3_gap_cnt", int'(sample_cnt), 4);
    end
    chk("t3_valid", int'(out_valid), 1);
    q.push_back('{36, 4, 0});
    out_ready = 1'b1;
    step(1'b0, 0);
    out_ready = 1'b0;
    block(10, 8);
    chk("t4_sum1", int'(sum_out), 80);
    chk("t4_ovr1", int'(overrun), 0);
    block(20, 8);
    chk("t4_sum2", int'(sum_out), 160);
    chk("t4_mean2", int'(mean_out), 20);
    chk("t4_valid", int'(out_valid), 1);
    chk("t4_ovr2", int'(overrun), 1);
    q.push_back('{160, 20, 1});
    block(5, 7);
    out_ready = 1'b1;
    step(1'b1, 5);
    out_ready = 1'b0;
    chk("t5_valid", int'(out_valid), 1);
    chk("t5_sum", int'(sum_out), 40);
    chk("t5_ovr", int'(overrun), 1);
    q.push_back('{40, 5, 1});
    out_ready = 1'b1;
    step(1'b0, 0);
    out_ready = 1'b0;
    chk("t5_valid_fall", int'(out_valid), 0);
    block(7, 5);
    chk("t6_cnt5", int'(sample_cnt), 5);
    clear = 1'b1;
    step(1'b1, 99);
    clear = 1'b0;
    chk("t6_clear_cnt", int'(sample_cnt), 0);
    chk("t6_clear_valid", int'(out_valid), 0);
    block(3, 8);
    q.push_back('{24, 3, 1});
    out_ready = 1'b1;
    step(1'b0, 0);
    out_ready = 1'b0;
    block(3, 4);
    chk("t6_cnt4", int'(sample_cnt), 4);
    reset = 1'b1;
    step(1'b1, 3);
    reset = 1'b0;
    chk("t7_sum", int'(sum_out), 0);
    chk("t7_mean", int'(mean_out), 0);
    chk("t7_valid", int'(out_valid), 0);
    chk("t7_ovr", int'(overrun), 0);
    chk("t7_cnt", int'(sample_cnt), 0);
    block(1, 8);
    chk("t7_fresh_sum", int'(sum_out), 8);
    step(1'b0, 0);
    chk("sb_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Stage directly downstream of the pipelined multiply-add register block, which produces A*B+C on DATA_OUT three cycles after its operands are applied.
- Accumulates N_SAMPLES consecutive valid products-plus-offsets into a block sum, and also produces the block mean.
- Presents each finished block on a valid/ready output.
- Accumulation never stalls, because the upstream stage has no backpressure. An unaccepted result is overwritten and flagged.

Parameters:
- OUT_WIDTH, 16, width of the upstream result word (unsigned); defined in the shared include.
- N_SAMPLES, 8, samples per block; power of two, >= 2.
- ACC_WIDTH, OUT_WIDTH + $clog2(N_SAMPLES), sum width; guarantees no overflow.

Ports:
- clk, in, 1, system clock; all logic on posedge.
- reset, in, 1, synchronous active-high reset.
- in_valid, in, 1, in_data is valid this cycle (upstream valid, delayed to align with DATA_OUT).
- in_data, in, OUT_WIDTH, upstream DATA_OUT word.
- clear, in, 1, synchronous restart of the current block; discards the partial sum.
- sum_out, out, ACC_WIDTH, completed block sum.
- mean_out, out, OUT_WIDTH, sum_out >> $clog2(N_SAMPLES) (truncating).
- out_valid, out, 1, sum_out/mean_out hold a result not yet accepted.
- out_ready, in, 1, consumer accepts when out_valid && out_ready.
- overrun, out, 1, sticky; a new result replaced an unaccepted one.
- sample_cnt, out, $clog2(N_SAMPLES), samples in the current partial block.

Behaviour:
- Reset: acc=0, sample_cnt=0, sum_out=0, mean_out=0, out_valid=0, overrun=0, state=ACCUM. Reset wins over every other input in the same cycle.
- States:
  - ACCUM: no result pending.
  - PENDING: out_valid=1.
  - The states are orthogonal to the accumulation counter, which runs in both.
- Sample accept: every cycle with in_valid=1 and clear=0 adds in_data (zero-extended) to acc and increments sample_cnt.
- Block completion: on the cycle sample_cnt==N_SAMPLES-1 with an accepted sample:
  - sum_out <= acc + in_data; mean_out <= that value >> log2(N).
  - acc <= 0; sample_cnt <= 0; out_valid <= 1.
  - The result is registered one cycle after the last sample, so latency is 1 clk from the Nth in_valid to out_valid.
- Back-to-back blocks: the first sample of the next block may arrive the cycle after completion and accumulates from 0. No bubble.
- Handshake:
  - out_valid falls the cycle after out_valid&&out_ready; sum_out/mean_out hold their value until replaced.
  - out_ready is ignored while out_valid=0.
- Simultaneous completion and acceptance (out_valid=1, out_ready=1, completion in same cycle): the old result is consumed, the new one loads, out_valid stays 1, overrun unchanged.
- Completion while out_valid=1 and out_ready=0: the new result overwrites, out_valid stays 1, overrun <= 1. overrun clears only on reset.
- clear:
  - acc <= 0 and sample_cnt <= 0; an in_valid sample in the same cycle is discarded.
  - clear does not affect out_valid, sum_out, mean_out or overrun.
  - clear on the completion cycle suppresses that completion.
- in_valid=0: acc and sample_cnt hold; gaps of any length are allowed inside a block.
- Arithmetic: unsigned. ACC_WIDTH must be >= OUT_WIDTH+log2(N); this is checked by an elaboration-time assertion. Max sum (2^16-1)*8 = 524280 fits in 19 bits.
- Reset mid-block: the partial sum is discarded and the next valid sample starts a fresh block.

Decomposition:
- Shared package/include: OUT_WIDTH (already shared with the multiply-add stage), N_SAMPLES default, ACC_WIDTH derivation, and an enum state_t {ACCUM, PENDING}.
- One natural sub-module, mac_out_slot: the output holding register with valid/ready and overrun logic, fed by a load strobe plus data.
- The accumulator and counter stay in the top module.

Test Plan:
- Reset then 8 consecutive samples of 100 -> out_valid rises 1 clk after the 8th; sum_out=800, mean_out=100; sample_cnt back to 0.
- 8 samples of 65535 with out_ready=1 -> sum_out=524280, mean_out=65535, no wrap; out_valid pulses for 1 cycle.
- Samples 1..8 with idle gaps (in_valid toggled 1,0,0,1...) -> sum_out=36, mean_out=4; acc holds across gaps.
- Two blocks back-to-back (16 contiguous samples of 10, 20) with out_ready=0 -> second completion gives sum_out=160, out_valid=1, overrun=1.
- Then a simultaneous test: out_ready=1 on the completion cycle of a third block -> out_valid stays 1 and overrun does not change.
- 5 samples of 7, then clear with in_valid=1 and data 99, then 8 samples of 3 -> sum_out=24; 99 discarded. Then reset asserted with sample_cnt=4 -> all outputs 0 the next cycle.
